cdb_arbiter: RTL and testbench

Shares the two common data buses (CDB1, CDB2) among the execution units. Each unit pushes completed results, {tag, value}, into a private 2-entry buffer. Every cycle the block grants up to two buffered results in round-robin order and broadcasts them on registered CDB outputs. The reservation stations and the register file snoop those outputs.

---
 rtl/core_pkg.sv | 22 ++
 rtl/cdb_fifo2.sv | 49 ++++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the common-data-bus arbiter.
//   TAG_W/DATA_W/CDB_W : widths of a broadcast {tag, value}
//   cdb_t              : packed {tag, value} as seen on a CDB
//   CDB_IDLE           : all-zero bus, tag 0 means "no broadcast"
//   UNIT_*             : requester index of each execution unit
package core_pkg;
   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;
   localparam int CDB_W  = TAG_W + DATA_W;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] value;
   } cdb_t;

   localparam cdb_t CDB_IDLE = '0;

   localparam int UNIT_ALU = 0;
   localparam int UNIT_LSU = 1;
   localparam int UNIT_BR  = 2;
   localparam int UNIT_MUL = 3;
endpackage

// File: rtl/cdb_fifo2.sv
// cdb_fifo2: two-entry result buffer for one execution unit.
//   clk, reset : clock, synchronous active-high reset
//   flush      : synchronous empty (misprediction kill)
//   push, din  : write din at the tail
//   pop        : drop the head (only when count != 0)
//   dout       : current head entry
//   count      : occupancy 0..2
module cdb_fifo2
   import core_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       push,
   input  cdb_t       din,
   input  logic       pop,
   output cdb_t       dout,
   output logic [1:0] count
);
   cdb_t mem [2];
   logic rd_ptr;
   logic wr_idx;
   logic clr;

   assign clr = reset | flush;
   // tail slot is rd_ptr when empty, the other slot when holding one entry
   assign wr_idx = rd_ptr ^ count[0];
   assign dout   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push && !clr)
         mem[wr_idx] <= din;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
      end else begin
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares CDB1/CDB2 among NREQ execution units.
//   clk, reset : clock, synchronous active-high reset
//   kill       : synchronous flush of all buffered results
//   req_valid  : unit i offers req_data[i]
//   req_data   : per-unit {tag, value}
//   req_ready  : unit i's buffer has room (flop-driven only)
//   cdb1, cdb2 : registered broadcasts, all-zero when idle
// Each unit has a 2-entry buffer; every cycle up to two non-empty heads are
// granted in round-robin order starting at rr_ptr and broadcast next edge.
module cdb_arbiter
   import core_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       kill,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ-1:0][CDB_W-1:0] req_data,
   output logic [NREQ-1:0]            req_ready,
   output logic [CDB_W-1:0]           cdb1,
   output logic [CDB_W-1:0]           cdb2
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   rr_ptr, rr_nxt;
   cdb_t            head [NREQ];
   logic [1:0]      cnt  [NREQ];
   logic [NREQ-1:0] eligible, discard, grant, push, pop;

   logic            v1, v2;
   logic [PW-1:0]   sel1, sel2, idx;
   logic [PW:0]     sum;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(NREQ - 1)) ? '0 : p + PW'(1);
   endfunction

   for (genvar g = 0; g < NREQ; g++) begin : g_unit
      cdb_fifo2 u_fifo (
         .clk   (clk),
         .reset (reset),
         .flush (kill),
         .push  (push[g]),
         .din   (req_data[g]),
         .pop   (pop[g]),
         .dout  (head[g]),
         .count (cnt[g])
      );
      assign req_ready[g] = (cnt[g] != 2'd2);
      assign push[g]      = req_valid[g] & req_ready[g];
      // tag-0 heads are never broadcast; they are dropped as soon as they surface
      assign eligible[g]  = (cnt[g] != 2'd0) && (head[g].tag != '0);
      assign discard[g]   = (cnt[g] != 2'd0) && (head[g].tag == '0);
      assign pop[g]       = (grant[g] | discard[g]) & ~kill;
   end

   // rotating scan rr_ptr, rr_ptr+1, ... : first hit -> cdb1, second -> cdb2
   always_comb begin
      v1     = 1'b0;
      v2     = 1'b0;
      sel1   = '0;
      sel2   = '0;
      sum    = '0;
      idx    = '0;
      grant  = '0;
      rr_nxt = rr_ptr;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ))
            sum = sum - (PW+1)'(NREQ);
         idx = sum[PW-1:0];
         if (eligible[idx]) begin
            if (!v1) begin
               v1   = 1'b1;
               sel1 = idx;
            end else if (!v2) begin
               v2   = 1'b1;
               sel2 = idx;
            end
         end
      end
      if (v1) grant[sel1] = 1'b1;
      if (v2) grant[sel2] = 1'b1;
      if (v2)
         rr_nxt = wrap_inc(sel2);
      else if (v1)
         rr_nxt = wrap_inc(sel1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
         cdb1   <= CDB_IDLE;
         cdb2   <= CDB_IDLE;
      end else if (kill) begin
         // rr_ptr deliberately held across a flush
         cdb1   <= CDB_IDLE;
         cdb2   <= CDB_IDLE;
      end else begin
         rr_ptr <= rr_nxt;
         cdb1   <= v1 ? head[sel1] : CDB_IDLE;
         cdb2   <= v2 ? head[sel2] : CDB_IDLE;
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
   import core_pkg::*;
   localparam int N = 4;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    kill = 1'b0;
   logic [N-1:0]            req_valid = '0;
   logic [N-1:0][CDB_W-1:0] req_data = '0;
   logic [N-1:0]            req_ready;
   logic [CDB_W-1:0]        cdb1, cdb2;

   always #5 clk = ~clk;

   cdb_arbiter #(.NREQ(N)) dut (
      .clk(clk), .reset(reset), .kill(kill), .req_valid(req_valid),
      .req_data(req_data), .req_ready(req_ready), .cdb1(cdb1), .cdb2(cdb2)
   );

   int   ncmp = 0, nerr = 0;
   cdb_t mq  [N][$];   // reference buffers
   cdb_t src [N][$];   // per-unit pending results (held until accepted)
   cdb_t seen[$];      // everything observed on the buses
   int   rr = 0;

   task automatic chk(input string name, input logic [CDB_W-1:0] act, input logic [CDB_W-1:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic cdb_t mk(input int t, input logic [31:0] v);
      cdb_t r;
      r.tag   = 6'(t);
      r.value = v;
      return r;
   endfunction

   // one clock: drive, advance, update reference model, compare
   task automatic step(input bit rst, input bit kl);
      logic [N-1:0] rdy, gnt, er;
      cdb_t e1, e2;
      int n, last, id;
      reset = rst;
      kill  = kl;
      for (int u = 0; u < N; u++) begin
         req_valid[u] = (src[u].size() > 0);
         req_data[u]  = req_valid[u] ? src[u][0] : '0;
         rdy[u]       = (mq[u].size() < 2);
      end
      @(posedge clk);
      e1 = CDB_IDLE; e2 = CDB_IDLE; gnt = '0; n = 0; last = -1;
      if (rst || kl) begin
         for (int u = 0; u < N; u++) begin
            mq[u].delete();
            src[u].delete();
         end
         if (rst) rr = 0;
      end else begin
         for (int k = 0; k < N; k++) begin
            id = (rr + k) % N;
            if (n < 2 && mq[id].size() > 0 && mq[id][0].tag != 0) begin
               if (n == 0) e1 = mq[id][0]; else e2 = mq[id][0];
               gnt[id] = 1'b1;
               last = id;
               n++;
            end
         end
         for (int u = 0; u < N; u++)
            if (gnt[u] || (mq[u].size() > 0 && mq[u][0].tag == 0))
               void'(mq[u].pop_front());
         for (int u = 0; u < N; u++)
            if (req_valid[u] && rdy[u]) begin
               mq[u].push_back(src[u][0]);
               void'(src[u].pop_front());
            end
         if (last >= 0) rr = (last + 1) % N;
      end
      #1;
      for (int u = 0; u < N; u++) er[u] = (mq[u].size() < 2);
      chk("model_ready", CDB_W'(req_ready), CDB_W'(er));
      chk("model_cdb1", cdb1, e1);
      chk("model_cdb2", cdb2, e2);
      if (cdb1[CDB_W-1 -: TAG_W] != 0) seen.push_back(cdb1);
      if (cdb2[CDB_W-1 -: TAG_W] != 0) seen.push_back(cdb2);
   endtask

   typedef struct packed {
      logic                    rst;
      logic [N-1:0]            vld;
      logic [N-1:0][CDB_W-1:0] d;
      logic [N-1:0]            rdy;
      logic [CDB_W-1:0]        c1, c2;
   } vec_t;

   function automatic vec_t row(input logic r, input logic [N-1:0] v,
                                input cdb_t d0, d1, d2, d3, input cdb_t c1, c2);
      vec_t x;
      x.rst = r; x.vld = v;
      x.d[0] = d0; x.d[1] = d1; x.d[2] = d2; x.d[3] = d3;
      x.rdy = '1; x.c1 = c1; x.c2 = c2;
      return x;
   endfunction

   initial begin
      vec_t tbl [14];
      cdb_t z;
      int sz0, u0n;
      int u0tags [$];
      z = CDB_IDLE;

      // ---------------- table-driven directed vectors ----------------
      tbl[0]  = row(1, 4'b0000, z, z, z, z, z, z);
      tbl[1]  = row(0, 4'b0000, z, z, z, z, z, z);
      tbl[2]  = row(0, 4'b0000, z, z, z, z, z, z);
      tbl[3]  = row(0, 4'b0000, z, z, z, z, z, z);
      tbl[4]  = row(0, 4'b0100, z, z, mk(5, 32'h1234), z, z, z);
      tbl[5]  = row(0, 4'b0000, z, z, z, z, mk(5, 32'h1234), z);
      tbl[6]  = row(0, 4'b0000, z, z, z, z, z, z);
      tbl[7]  = row(0, 4'b0010, z, mk(0, 32'hdeadbeef), z, z, z, z);
      tbl[8]  = row(0, 4'b0011, mk(7, 32'h7), mk(0, 32'hcafef00d), z, z, z, z);
      tbl[9]  = row(0, 4'b0000, z, z, z, z, mk(7, 32'h7), z);
      tbl[10] = row(0, 4'b0000, z, z, z, z, z, z);
      tbl[11] = row(0, 4'b1001, mk(9, 32'h9), z, z, mk(10, 32'ha), z, z);
      tbl[12] = row(0, 4'b0000, z, z, z, z, mk(10, 32'ha), mk(9, 32'h9));
      tbl[13] = row(0, 4'b0000, z, z, z, z, z, z);

      step(1, 0);
      for (int i = 0; i < 14; i++) begin
         for (int u = 0; u < N; u++) begin
            src[u].delete();
            if (tbl[i].vld[u]) src[u].push_back(tbl[i].d[u]);
         end
         step(tbl[i].rst, 0);
         chk($sformatf("tbl%0d_ready", i), CDB_W'(req_ready), CDB_W'(tbl[i].rdy));
         chk($sformatf("tbl%0d_cdb1", i), cdb1, tbl[i].c1);
         chk($sformatf("tbl%0d_cdb2", i), cdb2, tbl[i].c2);
      end

      // ---------------- round-robin with all units streaming ----------------
      step(1, 0);
      for (int u = 0; u < N; u++)
         for (int s = 0; s < 12; s++) src[u].push_back(mk(u * 16 + s + 1, $urandom));
      for (int c = 0; c < 8; c++) begin
         step(0, 0);
         if (c >= 1) begin
            chk($sformatf("rr%0d_unit1", c), CDB_W'(cdb1[CDB_W-1 -: 2]), CDB_W'((c % 2 == 1) ? 0 : 2));
            chk($sformatf("rr%0d_unit2", c), CDB_W'(cdb2[CDB_W-1 -: 2]), CDB_W'((c % 2 == 1) ? 1 : 3));
         end
      end

      // ---------------- backpressure on unit 0 ----------------
      step(1, 0);
      seen.delete();
      for (int u = 1; u < N; u++)
         for (int s = 0; s < 12; s++) src[u].push_back(mk(u * 16 + s + 1, $urandom));
      step(0, 0);
      step(0, 0);
      for (int t = 1; t <= 3; t++) src[UNIT_ALU].push_back(mk(t, 32'h100 + t));
      for (int c = 0; c < 30; c++) begin
         sz0 = src[UNIT_ALU].size();
         step(0, 0);
         if (sz0 == 2 && src[UNIT_ALU].size() == 1)
            chk("bp_ready0_after_2nd_push", CDB_W'(req_ready[0]), CDB_W'(0));
      end
      foreach (seen[i]) if (seen[i][CDB_W-1 -: TAG_W] < 4) u0tags.push_back(int'(seen[i][CDB_W-1 -: TAG_W]));
      u0n = u0tags.size();
      chk("bp_u0_count", CDB_W'(u0n), CDB_W'(3));
      for (int i = 0; i < u0n && i < 3; i++)
         chk($sformatf("bp_order%0d", i), CDB_W'(u0tags[i]), CDB_W'(i + 1));

      // ---------------- kill with busy buffers ----------------
      step(1, 0);
      for (int u = 0; u < N; u++)
         for (int s = 0; s < 12; s++) src[u].push_back(mk(u * 16 + s + 1, $urandom));
      for (int c = 0; c < 5; c++) step(0, 0);
      step(0, 1);
      chk("kill_cdb1", cdb1, CDB_IDLE);
      chk("kill_cdb2", cdb2, CDB_IDLE);
      chk("kill_ready", CDB_W'(req_ready), CDB_W'(4'b1111));
      step(0, 0);
      step(0, 0);
      chk("post_kill_idle", cdb1, CDB_IDLE);
      src[UNIT_MUL].push_back(mk(42, 32'h4b1d));
      step(0, 0);
      step(0, 0);
      chk("post_kill_first", cdb1, mk(42, 32'h4b1d));
      chk("post_kill_cdb2", cdb2, CDB_IDLE);

      // ---------------- randomized against reference model ----------------
      step(1, 0);
      for (int c = 0; c < 800; c++) begin
         for (int u = 0; u < N; u++)
            if (src[u].size() == 0 && $urandom_range(0, 1) == 1)
               src[u].push_back(mk(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63), $urandom));
         step($urandom_range(0, 149) == 0, $urandom_range(0, 24) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
